// File: rtl/control_unit_if.sv
// control_unit_if: executor redirect, pipeline flush, fetch request and fault signals of the control unit
interface control_unit_if;
    logic        set_pc;
    logic [31:0] new_pc;
    logic        flush;
    logic        fetch_valid;
    logic [31:0] fetch_addr;
    logic        fetch_ready;
    logic        fault;
    logic [31:0] fault_pc;
    modport master (
        input  set_pc, new_pc, fetch_ready,
        output flush, fetch_valid, fetch_addr, fault, fault_pc
    );
    modport slave (
        output set_pc, new_pc, fetch_ready,
        input  flush, fetch_valid, fetch_addr, fault, fault_pc
    );
endinterface

// File: rtl/control_unit.sv
// control_unit: owns the fetch PC, sequences redirect flushes and traps misaligned redirect targets
module control_unit #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic           clock,
    input  logic           reset,
    control_unit_if.master cu
);
    typedef enum logic [1:0] {RUN_WAIT, RUN, FLUSH, FAULT} state_t;
    localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYCLES - 1);
    state_t      r_state, w_state;
    logic [31:0] r_pc, w_pc, r_fetch_addr, w_fetch_addr, r_fault_pc, w_fault_pc;
    logic        r_flush, w_flush, r_fetch_valid, w_fetch_valid, r_fault, w_fault;
    logic [3:0]  r_cnt, w_cnt;
    logic [31:0] w_target;
    logic        w_redirect;
    assign w_target   = {cu.new_pc[31:1], 1'b0};
    assign w_redirect = cu.set_pc && (r_state == RUN_WAIT || r_state == RUN);
    always_comb begin
        w_state       = r_state;
        w_pc          = r_pc;
        w_fetch_addr  = r_fetch_addr;
        w_fault_pc    = r_fault_pc;
        w_flush       = r_flush;
        w_fetch_valid = r_fetch_valid;
        w_fault       = r_fault;
        w_cnt         = r_cnt;
        // a redirect swallows any same-cycle handshake without advancing pc
        if (w_redirect) begin
            w_flush       = 1'b1;
            w_fetch_valid = 1'b0;
            if (w_target[1]) begin
                w_state    = FAULT;
                w_fault    = 1'b1;
                w_fault_pc = w_target;
            end else begin
                w_state = FLUSH;
                w_pc    = w_target;
                w_cnt   = FLUSH_LAST;
            end
        end else begin
            case (r_state)
                RUN_WAIT: begin
                    w_state       = RUN;
                    w_fetch_valid = 1'b1;
                    w_fetch_addr  = r_pc;
                end
                RUN: begin
                    if (r_fetch_valid && cu.fetch_ready) begin
                        w_pc         = r_pc + 32'd4;
                        w_fetch_addr = r_pc + 32'd4;
                    end
                end
                FLUSH: begin
                    if (r_cnt == 4'd0) begin
                        w_state = RUN_WAIT;
                        w_flush = 1'b0;
                    end else begin
                        w_cnt = r_cnt - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= RUN_WAIT;
            r_pc          <= RESET_PC;
            r_fetch_addr  <= RESET_PC;
            r_fault_pc    <= 32'd0;
            r_flush       <= 1'b0;
            r_fetch_valid <= 1'b0;
            r_fault       <= 1'b0;
            r_cnt         <= 4'd0;
        end else begin
            r_state       <= w_state;
            r_pc          <= w_pc;
            r_fetch_addr  <= w_fetch_addr;
            r_fault_pc    <= w_fault_pc;
            r_flush       <= w_flush;
            r_fetch_valid <= w_fetch_valid;
            r_fault       <= w_fault;
            r_cnt         <= w_cnt;
        end
    end
    assign cu.flush       = r_flush;
    assign cu.fetch_valid = r_fetch_valid;
    assign cu.fetch_addr  = r_fetch_addr;
    assign cu.fault       = r_fault;
    assign cu.fault_pc    = r_fault_pc;
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed steps with hand-computed expectations, RESET_PC=0x100, FLUSH_CYCLES=2
module tb_control_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    control_unit_if cu();
    control_unit #(.RESET_PC(32'h0000_0100), .FLUSH_CYCLES(2)) dut (
        .clock(clk),
        .reset(rst),
        .cu(cu)
    );
    always #5 clk = ~clk;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic chk_ctl(input string tag, input logic fl, input logic fv, input logic ft);
        chk({tag, "_flush"}, 32'(cu.flush), 32'(fl));
        chk({tag, "_fvalid"}, 32'(cu.fetch_valid), 32'(fv));
        chk({tag, "_fault"}, 32'(cu.fault), 32'(ft));
    endtask
    initial begin
        cu.set_pc = 1'b0;
        cu.new_pc = 32'd0;
        cu.fetch_ready = 1'b0;
        tick();
        chk_ctl("reset", 1'b0, 1'b0, 1'b0);
        chk("reset_addr", cu.fetch_addr, 32'h100);
        chk("reset_fpc", cu.fault_pc, 32'h0);
        rst = 1'b0;
        cu.fetch_ready = 1'b1;
        tick();
        chk_ctl("first", 1'b0, 1'b1, 1'b0);
        chk("first_addr", cu.fetch_addr, 32'h100);
        tick();
        chk("s1_addr", cu.fetch_addr, 32'h104);
        cu.fetch_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_ctl("stall", 1'b0, 1'b1, 1'b0);
            chk("stall_addr", cu.fetch_addr, 32'h104);
        end
        cu.fetch_ready = 1'b1;
        tick();
        chk("s2_addr", cu.fetch_addr, 32'h108);
        tick();
        chk("s3_addr", cu.fetch_addr, 32'h10C);
        chk_ctl("s3", 1'b0, 1'b1, 1'b0);
        cu.set_pc = 1'b1;
        cu.new_pc = 32'h0000_2001;
        tick();
        cu.set_pc = 1'b0;
        chk_ctl("rd_n", 1'b1, 1'b0, 1'b0);
        tick();
        chk_ctl("rd_n1", 1'b1, 1'b0, 1'b0);
        tick();
        chk_ctl("rd_n2", 1'b0, 1'b0, 1'b0);
        tick();
        chk_ctl("rd_n3", 1'b0, 1'b1, 1'b0);
        chk("rd_addr", cu.fetch_addr, 32'h2000);
        tick();
        chk("rd_next", cu.fetch_addr, 32'h2004);
        cu.set_pc = 1'b1;
        cu.new_pc = 32'hFFFF_FFFC;
        tick();
        chk_ctl("wr_n", 1'b1, 1'b0, 1'b0);
        cu.new_pc = 32'h0000_0040;
        tick();
        chk_ctl("wr_n1", 1'b1, 1'b0, 1'b0);
        cu.set_pc = 1'b0;
        tick();
        chk_ctl("wr_n2", 1'b0, 1'b0, 1'b0);
        tick();
        chk("wr_addr", cu.fetch_addr, 32'hFFFF_FFFC);
        tick();
        chk("wrap_addr", cu.fetch_addr, 32'h0000_0000);
        chk_ctl("wrap", 1'b0, 1'b1, 1'b0);
        cu.set_pc = 1'b1;
        cu.new_pc = 32'h0000_0500;
        tick();
        chk_ctl("mf_n", 1'b1, 1'b0, 1'b0);
        cu.set_pc = 1'b0;
        rst = 1'b1;
        tick();
        chk_ctl("mf_rst", 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
        chk_ctl("mf_restart", 1'b0, 1'b1, 1'b0);
        chk("mf_addr", cu.fetch_addr, 32'h100);
        tick();
        chk("mf_next", cu.fetch_addr, 32'h104);
        cu.set_pc = 1'b1;
        cu.new_pc = 32'h0000_3007;
        tick();
        chk_ctl("flt", 1'b1, 1'b0, 1'b1);
        chk("flt_pc", cu.fault_pc, 32'h3006);
        cu.new_pc = 32'h0000_0200;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_ctl("flt_hold", 1'b1, 1'b0, 1'b1);
            chk("flt_hold_pc", cu.fault_pc, 32'h3006);
        end
        cu.set_pc = 1'b0;
        rst = 1'b1;
        tick();
        chk_ctl("flt_rst", 1'b0, 1'b0, 1'b0);
        chk("flt_rst_pc", cu.fault_pc, 32'h0);
        rst = 1'b0;
        tick();
        chk_ctl("flt_restart", 1'b0, 1'b1, 1'b0);
        chk("flt_restart_addr", cu.fetch_addr, 32'h100);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
